// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM state encoding and parity-type constants for transmitter and receiver
package uart_pkg;
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_t;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: transmitter request/line bundle; master drives P_DATA/DATA_VALID/PAR_EN/PAR_TYP, slave drives TX_OUT/Busy
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;
  modport master (output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, input TX_OUT, Busy);
  modport slave  (input P_DATA, DATA_VALID, PAR_EN, PAR_TYP, output TX_OUT, Busy);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: LSB-first shift register + bit counter; ports clk, rst(async low), i_load, i_en, i_data in; o_bit, o_done out
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_bit,
  output logic                  o_done
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;
  assign o_bit  = r_shift[0];
  assign o_done = i_en && r_cnt == LAST;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= '0;
    end else if (i_en) begin
      r_shift <= r_shift >> 1;
      r_cnt   <= o_done ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with optional parity; ports clk, rst(async low), bus (uart_tx_if.slave: P_DATA/DATA_VALID/PAR_EN/PAR_TYP in, TX_OUT/Busy out)
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input logic      clk,
  input logic      rst,
  uart_tx_if.slave bus
);
  state_t r_state;
  logic   r_par_en, r_par_typ, r_par, r_tx_out, r_busy;
  logic   w_accept, w_data, w_bit, w_done;
  assign w_accept   = bus.DATA_VALID && (r_state == IDLE || r_state == STOP);
  assign w_data     = r_state == DATA;
  assign bus.TX_OUT = r_tx_out;
  assign bus.Busy   = r_busy;
  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_accept),
    .i_en  (w_data),
    .i_data(bus.P_DATA),
    .o_bit (w_bit),
    .o_done(w_done)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_tx_out  <= 1'b1;
      r_busy    <= 1'b0;
      r_par_en  <= 1'b0;
      r_par_typ <= PAR_EVEN;
      r_par     <= 1'b0;
    end else begin
      r_state   <= w_accept ? START :
                   r_state == START ? DATA :
                   r_state == DATA ? (w_done ? (r_par_en ? PARITY : STOP) : DATA) :
                   r_state == PARITY ? STOP : IDLE;
      r_tx_out  <= r_state == START ? 1'b0 :
                   r_state == DATA ? w_bit :
                   r_state == PARITY ? (r_par_typ == PAR_ODD ? ~r_par : r_par) : 1'b1;
      r_busy    <= r_state != IDLE;
      r_par_en  <= w_accept ? bus.PAR_EN : r_par_en;
      r_par_typ <= w_accept ? bus.PAR_TYP : r_par_typ;
      r_par     <= w_accept ? 1'b0 : w_data ? r_par ^ w_bit : r_par;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized + directed self-checking bench for uart_tx with a frame-queue line model and a loopback receiver
module tb_uart_tx;
  import uart_pkg::*;
  localparam int DW = 8;
  typedef struct {
    logic [DW-1:0] d;
    logic          pe;
    logic          pt;
  } frm_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_tx_if #(.DATA_WIDTH(DW)) bus ();
  uart_tx #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_fail = 0;
  int n_acc = 0;
  int acc0 = 0;
  int rx_pos = 0;
  bit exp_q[$];
  bit line_log[$];
  bit busy_log[$];
  frm_t sent_q[$];
  frm_t f, g;
  bit acc, exp_tx, exp_busy;
  logic [DW-1:0] rx_data;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic check_str(input string name, input string got, input string exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %s expected %s at %0t", name, got, exp, $time);
    end
  endtask
  function automatic string log_str(input bit busy, input int len);
    string s = "";
    for (int i = 0; i < len; i++) s = {s, (busy ? busy_log[i] : line_log[i]) ? "1" : "0"};
    return s;
  endfunction
  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
    bus.P_DATA = d;
    bus.PAR_EN = pe;
    bus.PAR_TYP = pt;
    bus.DATA_VALID = 1'b1;
    line_log.delete();
    busy_log.delete();
    @(negedge clk);
    bus.DATA_VALID = 1'b0;
  endtask
  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
      sent_q.delete();
      exp_tx = 1'b1;
      exp_busy = 1'b0;
    end else begin
      acc = bus.DATA_VALID === 1'b1 && exp_q.size() <= 1;
      exp_busy = exp_q.size() != 0;
      exp_tx = 1'b1;
      if (exp_busy) exp_tx = exp_q.pop_front();
      if (acc) begin
        f = '{bus.P_DATA, bus.PAR_EN, bus.PAR_TYP};
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(f.d[i]);
        if (f.pe) exp_q.push_back(^f.d ^ (f.pt == PAR_ODD));
        exp_q.push_back(1'b1);
        sent_q.push_back(f);
        n_acc++;
      end
    end
    #1;
    check("tx_out", bus.TX_OUT, exp_tx);
    check("busy", bus.Busy, exp_busy);
    line_log.push_back(bus.TX_OUT);
    busy_log.push_back(bus.Busy);
    if (!rst) rx_pos = 0;
    else if (rx_pos == 0) begin
      if (bus.TX_OUT == 1'b0) rx_pos = 1;
    end else if (rx_pos <= DW) begin
      rx_data[rx_pos-1] = bus.TX_OUT;
      rx_pos++;
    end else begin
      check("rx_has_frame", sent_q.size() != 0, 1);
      if (sent_q.size() != 0) begin
        g = sent_q[0];
        if (g.pe && rx_pos == DW + 1) begin
          check("rx_parity", bus.TX_OUT, ^rx_data ^ (g.pt == PAR_ODD));
          rx_pos++;
        end else begin
          check("rx_stop", bus.TX_OUT, 1);
          check("rx_data", rx_data, g.d);
          void'(sent_q.pop_front());
          rx_pos = 0;
        end
      end else rx_pos = 0;
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    bus.P_DATA = '0;
    bus.DATA_VALID = 1'b0;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = PAR_EVEN;
    #1 rst = 1'b0;
    #1;
    check("reset_tx", bus.TX_OUT, 1);
    check("reset_busy", bus.Busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send(8'hA5, 1'b0, PAR_EVEN);
    repeat (14) @(negedge clk);
    check_str("a5_line", log_str(0, 12), "101010010111");
    check_str("a5_busy", log_str(1, 12), "011111111110");
    send(8'hA5, 1'b1, PAR_EVEN);
    repeat (14) @(negedge clk);
    check_str("a5_even_line", log_str(0, 13), "1010100101011");
    check_str("a5_even_busy", log_str(1, 13), "0111111111110");
    send(8'hA5, 1'b1, PAR_ODD);
    repeat (14) @(negedge clk);
    check_str("a5_odd_line", log_str(0, 13), "1010100101111");
    check_str("a5_odd_busy", log_str(1, 13), "0111111111110");
    bus.PAR_EN = 1'b0;
    bus.P_DATA = 8'h01;
    bus.DATA_VALID = 1'b1;
    line_log.delete();
    busy_log.delete();
    @(negedge clk);
    bus.P_DATA = 8'hFF;
    repeat (10) @(negedge clk);
    bus.DATA_VALID = 1'b0;
    repeat (14) @(negedge clk);
    check_str("b2b_line", log_str(0, 22), "1010000000101111111111");
    check_str("b2b_busy", log_str(1, 22), "0111111111111111111110");
    send(8'h3C, 1'b0, PAR_EVEN);
    repeat (2) @(negedge clk);
    bus.P_DATA = 8'h00;
    bus.PAR_EN = 1'b1;
    bus.DATA_VALID = 1'b1;
    @(negedge clk);
    bus.DATA_VALID = 1'b0;
    repeat (14) @(negedge clk);
    check_str("ignore_line", log_str(0, 12), "100011110011");
    check_str("ignore_busy", log_str(1, 12), "011111111110");
    send(8'h5A, 1'b0, PAR_EVEN);
    repeat (5) @(negedge clk);
    check("midframe_busy", bus.Busy, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_tx", bus.TX_OUT, 1);
    check("abort_busy", bus.Busy, 0);
    repeat (2) @(negedge clk);
    check("held_tx", bus.TX_OUT, 1);
    rst = 1'b1;
    send(8'h96, 1'b1, PAR_ODD);
    repeat (14) @(negedge clk);
    check_str("after_rst_line", log_str(0, 13), "1001101001111");
    check_str("after_rst_busy", log_str(1, 13), "0111111111110");
    acc0 = n_acc;
    for (int c = 0; c < 40000 && n_acc - acc0 < 1000; c++) begin
      bus.DATA_VALID = $urandom_range(0, 2) != 0;
      bus.P_DATA = DW'($urandom);
      bus.PAR_EN = 1'($urandom);
      bus.PAR_TYP = 1'($urandom);
      @(negedge clk);
    end
    bus.DATA_VALID = 1'b0;
    check("random_frames", n_acc - acc0 >= 1000, 1);
    repeat (15) @(negedge clk);
    check("all_frames_received", sent_q.size(), 0);
    check("line_idle", bus.TX_OUT, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload bits per frame.
REQ-002 SHALL have port clk  input  1  transmit bit clock; one serial bit per clk cycle.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel payload to send.
REQ-005 SHALL have port DATA_VALID  input  1  request strobe; P_DATA, PAR_EN and PAR_TYP are qualified on the same edge.
REQ-006 SHALL have port PAR_EN  input  1  1 = parity bit inserted between data and stop.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port TX_OUT  output  1  serial line, registered, idle high.
REQ-009 SHALL have port Busy  output  1  registered; high while a frame is being driven.

Function
REQ-010 SHALL use a one-hot FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-011 SHALL accept a request only on an edge where DATA_VALID=1 and the state is IDLE or STOP; DATA_VALID in START, DATA or PARITY SHALL be ignored, with no queuing.
REQ-012 SHALL latch P_DATA, PAR_EN and PAR_TYP on acceptance; later input changes SHALL NOT affect the frame in flight.
REQ-013 Latency: acceptance at edge N SHALL drive TX_OUT=0 (start bit) for the cycle following edge N+1.
REQ-014 START: one cycle, TX_OUT=0, then DATA.
REQ-015 DATA: DATA_WIDTH cycles, LSB first, driven from a shift register, with a bit counter 0..DATA_WIDTH-1.
REQ-016 After the last data bit, the FSM SHALL go to PARITY if the latched PAR_EN=1, otherwise to STOP.
REQ-017 PARITY: one cycle; even: TX_OUT = XOR of the latched data; odd: TX_OUT = its inverse.
REQ-018 STOP: one cycle, TX_OUT=1; then START if a request is accepted in that cycle (back-to-back, no idle gap), otherwise IDLE.
REQ-019 Frame length SHALL be DATA_WIDTH+2 cycles without parity and DATA_WIDTH+3 with parity.
REQ-020 Busy SHALL rise together with the start bit and fall with the first idle-high cycle after STOP; it SHALL stay high across back-to-back frames.
REQ-021 TX_OUT in IDLE SHALL be 1; TX_OUT SHALL never glitch, as it is a flop output.
REQ-022 Parity SHALL be computed from the latched data, never from the live P_DATA.

Reset
REQ-023 On rst=0 the block SHALL asynchronously go to IDLE, with TX_OUT=1, Busy=0, the bit counter at 0 and the shift register at 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately; after release, the line SHALL stay high until a new request is accepted.
REQ-025 DATA_VALID high in the first edge after reset release SHALL be accepted normally.

Structure
REQ-026 Shared package uart_pkg SHALL hold the state encoding and the parity-type constants (PAR_EVEN=0, PAR_ODD=1), shared with the receiver.
REQ-027 Sub-module uart_tx_serializer SHALL hold the shift register and bit counter, with load, enable and done signals; the FSM, parity and output mux SHALL live in uart_tx.

Verification
REQ-028 P_DATA=0xA5, PAR_EN=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1, then idle 1; Busy high for exactly 10 cycles.
REQ-029 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0; with PAR_TYP=1 -> parity bit 1; frame is 11 cycles.
REQ-030 0x01 then 0xFF, with DATA_VALID held high in the STOP cycle of the first frame -> the second start bit directly follows the stop bit; Busy never drops.
REQ-031 P_DATA changed to 0x00 and DATA_VALID pulsed during the DATA state of a 0x3C frame -> 0x3C is sent intact and the pulse is ignored.
REQ-032 rst asserted at data bit 4 -> TX_OUT=1 and Busy=0 immediately; the next request is sent as a clean full frame.
REQ-033 Randomized payload, PAR_EN and PAR_TYP, looped back into the existing receiver -> received data matches, with no parity or stop errors over 1000 frames.
